stopwatch_core: RTL and testbench
=================================

STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 SHALL have parameter MAX_MIN, default 59, meaning the highest minutes value before wrap (range 1..99).
REQ-002 SHALL have port clk, input, 1, the single master clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-004 SHALL have port one_hz_tick, input, 1, one-cycle count enable at 1 Hz.
REQ-005 SHALL have port two_hz_tick, input, 1, one-cycle adjust enable at 2 Hz.
REQ-006 SHALL have port pause_pulse, input, 1, one-cycle debounced pause-button pulse.
REQ-007 SHALL have port adj, input, 1, level; 1 = adjust mode.
REQ-008 SHALL have port sel, input, 1, level; 0 = adjust minutes, 1 = adjust seconds.
REQ-009 SHALL have port tenth_min_cath, output, 7, active-low segments for the minutes tens digit.
REQ-010 SHALL have port ones_min_cath, output, 7, active-low segments for the minutes ones digit.
REQ-011 SHALL have port tenth_sec_cath, output, 7, active-low segments for the seconds tens digit.
REQ-012 SHALL have port ones_sec_cath, output, 7, active-low segments for the seconds ones digit.
REQ-013 SHALL have port running, output, 1, 1 when the run state is RUNNING.

Function
REQ-014 SHALL hold time as four BCD registers: min_t, min_o, sec_t, sec_o.
REQ-015 SHALL implement run state PAUSED/RUNNING; each pause_pulse toggles it, whatever the value of adj.
REQ-016 SHALL, when adj=0, RUNNING and one_hz_tick=1, increment seconds by 1.
REQ-017 SHALL wrap seconds 59->00 with carry into minutes; minutes MAX_MIN->00 without further carry; MAX_MIN:59 -> 00:00.
REQ-018 SHALL, when adj=1, ignore one_hz_tick.
REQ-019 SHALL, when adj=1, increment the field chosen by sel by 1 on each two_hz_tick, wrapping 59->00 (minutes MAX_MIN->00) with no carry into the other field.
REQ-020 SHALL use the run state before any toggle for a tick that arrives in the same cycle as pause_pulse; RUNNING+tick+pulse counts once, then pauses.
REQ-021 SHALL keep the run state unchanged across adj transitions; counting resumes from the adjusted value on the first one_hz_tick after adj falls, if RUNNING.
REQ-022 SHALL ignore a sel change in the same cycle as two_hz_tick except for the current-cycle sel value, which chooses the field.
REQ-023 SHALL register the cathode outputs from the BCD registers, so a digit change appears on the cathodes exactly 1 clk later.
REQ-024 SHALL decode digits as {g,f,e,d,c,b,a}, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-025 SHALL drive 1111111 (blank) for any BCD value above 9.
REQ-026 SHALL drive running combinationally from the run-state register.

Reset
REQ-027 SHALL, on rst=1 and independent of clk, clear all BCD registers to 0 and set the run state to PAUSED.
REQ-028 SHALL, on rst=1, drive all four cathode outputs to 1000000 and running to 0.
REQ-029 SHALL, on reset asserted mid-count or mid-adjust, discard the in-flight increment; the first count after release follows the first qualifying tick.

Structure
REQ-030 SHALL place the run-state encoding and the ten segment constants plus the blank constant in the shared stopwatch package.
REQ-031 SHALL instantiate sub-module seg7_decoder (4-bit BCD in, 7-bit active-low out) four times, once per digit.
REQ-032 SHALL feed segment_display directly; outputs SHALL connect one-to-one to its cathode inputs.

Verification
REQ-033 SHALL cover reset then one pause_pulse then 60 one_hz_ticks -> 01:00; ones_sec_cath=1000000 and ones_min_cath=1111001 one clk after the 60th tick.
REQ-034 SHALL cover preloading 59:59 (MAX_MIN=59), RUNNING, one tick -> 00:00 with no overflow artefacts.
REQ-035 SHALL cover adj=1, sel=1 from 00:58 with 3 two_hz_ticks -> 00:01, minutes unchanged; one_hz_ticks during adj have no effect.
REQ-036 SHALL cover RUNNING at 00:10 with pause_pulse and one_hz_tick in the same cycle -> 00:11 and running=0; further ticks leave 00:11.
REQ-037 SHALL cover rst asserted between clk edges while at 12:34 -> outputs 1000000 and running=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/stopwatch_core_pkg.sv
// Shared definitions for the stopwatch: run-state encoding and
// active-low seven-segment patterns ordered {g,f,e,d,c,b,a}.
package stopwatch_core_pkg;

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } run_state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/stopwatch_core_seg7_decoder.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes blank.
module seg7_decoder
  import stopwatch_core_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup, no state.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch with pause toggle, 2 Hz field adjust and registered
// active-low seven-segment cathode outputs.
module stopwatch_core
  import stopwatch_core_pkg::*;
#(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       one_hz_tick,
  input  logic       two_hz_tick,
  input  logic       pause_pulse,
  input  logic       adj,
  input  logic       sel,
  output logic [6:0] tenth_min_cath,
  output logic [6:0] ones_min_cath,
  output logic [6:0] tenth_sec_cath,
  output logic [6:0] ones_sec_cath,
  output logic       running
);

  localparam logic [3:0] MIN_T_MAX = 4'(MAX_MIN / 10);
  localparam logic [3:0] MIN_O_MAX = 4'(MAX_MIN % 10);

  run_state_t state_q, state_d;
  logic [3:0] min_t, min_o, sec_t, sec_o;
  logic [3:0] min_t_d, min_o_d, sec_t_d, sec_o_d;
  logic       cnt_en, adj_sec, adj_min, sec_wrap, min_wrap;
  logic [6:0] seg_min_t_p0, seg_min_o_p0, seg_sec_t_p0, seg_sec_o_p0;

  // Run-state register; reset always lands in PAUSED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PAUSED;
    else     state_q <= state_d;
  end

  // Pause toggling; a tick in the same cycle still sees the old state_q.
  always_comb begin
    state_d = state_q;
    if (pause_pulse) state_d = (state_q == RUNNING) ? PAUSED : RUNNING;
  end

  assign running = (state_q == RUNNING);

  // Increment qualifiers: counting carries into minutes, adjusting never does.
  assign cnt_en   = !adj && (state_q == RUNNING) && one_hz_tick;
  assign adj_sec  = adj && two_hz_tick && sel;
  assign adj_min  = adj && two_hz_tick && !sel;
  assign sec_wrap = (sec_t == 4'd5) && (sec_o == 4'd9);
  assign min_wrap = (min_t == MIN_T_MAX) && (min_o == MIN_O_MAX);

  // Next BCD time value.
  always_comb begin
    min_t_d = min_t;
    min_o_d = min_o;
    sec_t_d = sec_t;
    sec_o_d = sec_o;
    if (cnt_en || adj_sec) begin
      if (sec_o == 4'd9) begin
        sec_o_d = 4'd0;
        sec_t_d = (sec_t == 4'd5) ? 4'd0 : sec_t + 4'd1;
      end else begin
        sec_o_d = sec_o + 4'd1;
      end
    end
    if ((cnt_en && sec_wrap) || adj_min) begin
      if (min_wrap) begin
        min_t_d = 4'd0;
        min_o_d = 4'd0;
      end else if (min_o == 4'd9) begin
        min_o_d = 4'd0;
        min_t_d = min_t + 4'd1;
      end else begin
        min_o_d = min_o + 4'd1;
      end
    end
  end

  // BCD time registers, cleared asynchronously so an in-flight tick is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_t <= 4'd0;
      min_o <= 4'd0;
      sec_t <= 4'd0;
      sec_o <= 4'd0;
    end else begin
      min_t <= min_t_d;
      min_o <= min_o_d;
      sec_t <= sec_t_d;
      sec_o <= sec_o_d;
    end
  end

  // ---- stage p0: combinational digit decode ----
  seg7_decoder u_dec_min_t (.bcd(min_t), .seg(seg_min_t_p0));
  seg7_decoder u_dec_min_o (.bcd(min_o), .seg(seg_min_o_p0));
  seg7_decoder u_dec_sec_t (.bcd(sec_t), .seg(seg_sec_t_p0));
  seg7_decoder u_dec_sec_o (.bcd(sec_o), .seg(seg_sec_o_p0));

  // ---- stage p1: registered cathodes, showing "0" while in reset ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tenth_min_cath <= SEG_0;
      ones_min_cath  <= SEG_0;
      tenth_sec_cath <= SEG_0;
      ones_sec_cath  <= SEG_0;
    end else begin
      tenth_min_cath <= seg_min_t_p0;
      ones_min_cath  <= seg_min_o_p0;
      tenth_sec_cath <= seg_sec_t_p0;
      ones_sec_cath  <= seg_sec_o_p0;
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: stimulus pushes expected MM:SS and
// run flag; a negedge monitor pops and compares against the cathodes.
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       one_hz_tick = 1'b0;
  logic       two_hz_tick = 1'b0;
  logic       pause_pulse = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [6:0] tenth_min_cath, ones_min_cath, tenth_sec_cath, ones_sec_cath;
  logic       running;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    logic [3:0] mt, mo, st, so;
    logic       run;
  } exp_t;

  exp_t sb[$];

  stopwatch_core #(.MAX_MIN(59)) dut (
    .clk(clk), .rst(rst), .one_hz_tick(one_hz_tick), .two_hz_tick(two_hz_tick),
    .pause_pulse(pause_pulse), .adj(adj), .sel(sel),
    .tenth_min_cath(tenth_min_cath), .ones_min_cath(ones_min_cath),
    .tenth_sec_cath(tenth_sec_cath), .ones_sec_cath(ones_sec_cath),
    .running(running)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Monitor: compare every queued expectation mid-cycle.
  exp_t e;
  logic [27:0] got_c, exp_c;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got_c = {tenth_min_cath, ones_min_cath, tenth_sec_cath, ones_sec_cath};
      exp_c = {seg(e.mt), seg(e.mo), seg(e.st), seg(e.so)};
      n_vec++;
      if (got_c !== exp_c || running !== e.run) begin
        n_err++;
        $display("FAIL %s: got cath=%b_%b_%b_%b running=%b, expected cath=%b_%b_%b_%b running=%b (%0d%0d:%0d%0d)",
                 e.name, tenth_min_cath, ones_min_cath, tenth_sec_cath, ones_sec_cath, running,
                 exp_c[27:21], exp_c[20:14], exp_c[13:7], exp_c[6:0], e.run, e.mt, e.mo, e.st, e.so);
      end
    end
  end

  task automatic push_exp(input string nm, input int mm, input int ss, input logic run);
    exp_t x;
    x.name = nm;
    x.mt = 4'(mm / 10); x.mo = 4'(mm % 10);
    x.st = 4'(ss / 10); x.so = 4'(ss % 10);
    x.run = run;
    sb.push_back(x);
  endtask

  // Wait one edge so the cathode register catches up, then expect.
  task automatic chk(input string nm, input int mm, input int ss, input logic run);
    @(posedge clk); #1;
    push_exp(nm, mm, ss, run);
  endtask

  // One-cycle pulses on the chosen strobes.
  task automatic cyc(input logic oh, input logic th, input logic pp);
    @(posedge clk); #1;
    one_hz_tick = oh; two_hz_tick = th; pause_pulse = pp;
    @(posedge clk); #1;
    one_hz_tick = 1'b0; two_hz_tick = 1'b0; pause_pulse = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state, during and after reset
    repeat (2) @(posedge clk);
    #1 push_exp("in_reset", 0, 0, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    chk("after_reset", 0, 0, 1'b0);

    // Start and count 60 seconds
    cyc(1'b0, 1'b0, 1'b1);
    chk("started", 0, 0, 1'b1);
    repeat (10) cyc(1'b1, 1'b0, 1'b0);
    chk("count_10", 0, 10, 1'b1);
    repeat (49) cyc(1'b1, 1'b0, 1'b0);
    chk("count_59", 0, 59, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    push_exp("tick60_latency", 0, 59, 1'b1);
    chk("count_60", 1, 0, 1'b1);

    // Adjust seconds while running; one_hz ignored
    do_reset();
    chk("reset2", 0, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    adj = 1'b1; sel = 1'b1;
    repeat (58) cyc(1'b0, 1'b1, 1'b0);
    chk("adj_sec_58", 0, 58, 1'b1);
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    chk("adj_sec_wrap", 0, 1, 1'b1);
    repeat (4) cyc(1'b1, 1'b0, 1'b0);
    chk("adj_ignores_1hz", 0, 1, 1'b1);
    sel = 1'b0;
    repeat (2) cyc(1'b0, 1'b1, 1'b0);
    chk("adj_min", 2, 1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("pause_in_adj", 2, 1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    adj = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    chk("resume_after_adj", 2, 2, 1'b1);

    // Tick and pause in the same cycle
    do_reset();
    cyc(1'b0, 1'b0, 1'b1);
    repeat (10) cyc(1'b1, 1'b0, 1'b0);
    chk("at_00_10", 0, 10, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("tick_and_pause", 0, 11, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk("paused_hold", 0, 11, 1'b0);

    // Preload 59:59 and roll over
    adj = 1'b1; sel = 1'b0;
    repeat (59) cyc(1'b0, 1'b1, 1'b0);
    sel = 1'b1;
    repeat (48) cyc(1'b0, 1'b1, 1'b0);
    adj = 1'b0;
    chk("preload_59_59", 59, 59, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("rollover", 0, 0, 1'b1);

    // Adjust wraps without carry
    adj = 1'b1; sel = 1'b1;
    repeat (60) cyc(1'b0, 1'b1, 1'b0);
    chk("adj_sec_nocarry", 0, 0, 1'b1);
    sel = 1'b0;
    repeat (60) cyc(1'b0, 1'b1, 1'b0);
    chk("adj_min_wrap", 0, 0, 1'b1);

    // Reach 12:34, then asynchronous reset mid-cycle with a tick in flight
    repeat (12) cyc(1'b0, 1'b1, 1'b0);
    sel = 1'b1;
    repeat (34) cyc(1'b0, 1'b1, 1'b0);
    adj = 1'b0;
    chk("at_12_34", 12, 34, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; one_hz_tick = 1'b1;
    push_exp("async_reset", 0, 0, 1'b0);
    @(posedge clk); #1 one_hz_tick = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    chk("post_reset", 0, 0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("paused_after_reset", 0, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("first_count", 0, 1, 1'b1);

    // Drain scoreboard
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
